// File: rtl/piso_serializer_ctrl_pkg.sv
// Shared encodings for the PISO serializer: FSM states, shift-direction codes
// and a counter-width helper.
package piso_serializer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // A modulo-n counter needs at least one bit, even when n is 1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer_ctrl_if.sv
// Word-in / bit-out signal bundle for the PISO serializer.
// The master side is the producer and serial consumer; the slave side is the serializer.
interface piso_serializer_ctrl_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_dir;
  logic         ser_out;
  logic         ser_valid;
  logic         busy;
  logic         done;

  modport master (
    output in_valid, in_data, in_dir,
    input  in_ready, ser_out, ser_valid, busy, done
  );

  modport slave (
    input  in_valid, in_data, in_dir,
    output in_ready, ser_out, ser_valid, busy, done
  );
endinterface

// File: rtl/piso_serializer_ctrl_bit_tick_gen.sv
// Modulo-DIV pacing counter: counts while enabled and raises tick on the
// terminal count, then wraps to zero.
module bit_tick_gen
  import piso_serializer_ctrl_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/piso_serializer_ctrl.sv
// Parallel-in/serial-out serializer: latches a word on valid/ready, shifts it
// out LSB- or MSB-first with each bit held DIV clocks, then pulses done.
module piso_serializer_ctrl
  import piso_serializer_ctrl_pkg::*;
#(
  parameter int N   = 4,
  parameter int DIV = 1
) (
  input logic                  clk,
  input logic                  reset,
  piso_serializer_ctrl_if.slave bus
);
  localparam int BW = $clog2(N);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  state_t          state_q, state_d;
  logic [N-1:0]    shreg_q, shreg_d;
  logic            dir_q, dir_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            shifting;
  logic            tick;

  assign shifting = (state_q == ST_SHIFT);

  // The pacing counter is held at zero outside SHIFT, so every word starts fresh.
  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (reset),
    .en   (shifting),
    .clr  (!shifting),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    dir_d     = dir_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          shreg_d   = bus.in_data;
          dir_d     = bus.in_dir;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          shreg_d = (dir_q == DIR_LEFT) ? {shreg_q[N-2:0], 1'b0}
                                        : {1'b0, shreg_q[N-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = ST_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      dir_q     <= DIR_RIGHT;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      dir_q     <= dir_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Outputs decode registered state only; in_* never reach them combinationally.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.busy      = shifting;
  assign bus.ser_valid = shifting;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.ser_out   = shifting && ((dir_q == DIR_LEFT) ? shreg_q[N-1] : shreg_q[0]);
endmodule

// File: tb/tb_piso_serializer_ctrl.sv
// Directed bench for piso_serializer_ctrl: one instance with DIV=1 and one with
// DIV=2, each output vector compared cycle by cycle against hand-written values.
module tb_piso_serializer_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst2;

  piso_serializer_ctrl_if #(.N(N)) if1 ();
  piso_serializer_ctrl_if #(.N(N)) if2 ();

  piso_serializer_ctrl #(.N(N), .DIV(1)) dut1 (.clk(clk), .reset(rst1), .bus(if1.slave));
  piso_serializer_ctrl #(.N(N), .DIV(2)) dut2 (.clk(clk), .reset(rst2), .bus(if2.slave));

  // Observed vector: {in_ready, busy, ser_valid, done, ser_out}
  logic [4:0] o1, o2;
  assign o1 = {if1.in_ready, if1.busy, if1.ser_valid, if1.done, if1.ser_out};
  assign o2 = {if2.in_ready, if2.busy, if2.ser_valid, if2.done, if2.ser_out};

  localparam logic [4:0] V_IDLE = 5'b10000;
  localparam logic [4:0] V_DONE = 5'b00010;
  localparam logic [4:0] V_SH0  = 5'b01100;
  localparam logic [4:0] V_SH1  = 5'b01101;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] outv(input int sel);
    return (sel == 0) ? o1 : o2;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [N-1:0] d, input logic dir);
    if (sel == 0) begin
      if1.in_valid = v; if1.in_data = d; if1.in_dir = dir;
    end else begin
      if2.in_valid = v; if2.in_data = d; if2.in_dir = dir;
    end
  endtask

  // Accept one word at cycle 0, check every SHIFT cycle against exp_seq
  // (first serial bit is exp_seq[len-1]), then the DONE cycle and return to IDLE.
  task automatic run_word(input string name, input int sel, input logic [N-1:0] data,
                          input logic dir, input logic [7:0] exp_seq, input bit toggle);
    int   len;
    logic dir_t;
    len   = (sel == 0) ? N : 2 * N;
    dir_t = dir;
    chk($sformatf("%s idle_c0", name), outv(sel), V_IDLE);
    drive(sel, 1'b1, data, dir);
    @(negedge clk);
    drive(sel, 1'b0, data, dir);
    for (int i = 0; i < len; i++) begin
      if (toggle) begin
        dir_t = ~dir_t;
        drive(sel, 1'b0, ~data, dir_t);
      end
      chk($sformatf("%s shift_c%0d", name, i + 1), outv(sel), {4'b0110, exp_seq[len-1-i]});
      @(negedge clk);
    end
    chk($sformatf("%s done_c%0d", name, len + 1), outv(sel), V_DONE);
    @(negedge clk);
    chk($sformatf("%s ready_c%0d", name, len + 2), outv(sel), V_IDLE);
  endtask

  logic [4:0] e3 [5];

  initial begin
    rst1 = 1'b1; rst2 = 1'b1;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("reset div1", o1, V_IDLE);
    chk("reset div2", o2, V_IDLE);
    rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);

    // 1. MSB-first, DIV=1
    run_word("t1", 0, 4'b1011, 1'b1, 8'b0000_1011, 1'b0);
    // 2. LSB-first, DIV=2: 1,1,1,1,0,0,1,1
    run_word("t2", 1, 4'b1011, 1'b0, 8'b1111_0011, 1'b0);

    // 3. Second word offered while busy must wait until IDLE
    @(negedge clk);
    chk("t3 idle_c0", o1, V_IDLE);
    drive(0, 1'b1, 4'b1011, 1'b1);
    @(negedge clk);
    drive(0, 1'b1, 4'hA, 1'b1);
    e3[0] = V_SH1; e3[1] = V_SH0; e3[2] = V_SH1; e3[3] = V_SH1; e3[4] = V_DONE;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t3 busy_c%0d", c + 1), o1, e3[c]);
      @(negedge clk);
    end
    chk("t3 ready_c6", o1, V_IDLE);
    @(negedge clk);
    drive(0, 1'b0, 4'h0, 1'b0);
    chk("t3 a_bit0_c7", o1, V_SH1);
    @(negedge clk);
    chk("t3 a_bit1_c8", o1, V_SH0);
    @(negedge clk);
    chk("t3 a_bit2_c9", o1, V_SH1);
    @(negedge clk);
    chk("t3 a_bit3_c10", o1, V_SH0);
    @(negedge clk);
    chk("t3 a_done_c11", o1, V_DONE);
    @(negedge clk);
    chk("t3 a_idle_c12", o1, V_IDLE);

    // 4. Reset mid-word on the DIV=2 instance
    @(negedge clk);
    chk("t4 idle_c0", o2, V_IDLE);
    drive(1, 1'b1, 4'b1011, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, 4'b1011, 1'b0);
    chk("t4 shift_c1", o2, V_SH1);
    @(negedge clk);
    chk("t4 shift_c2", o2, V_SH1);
    @(negedge clk);
    chk("t4 shift_c3", o2, V_SH1);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    chk("t4 after_reset", o2, V_IDLE);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("t4 no_done_%0d", c), o2, V_IDLE);
    end

    // 5. in_dir / in_data wiggling during SHIFT has no effect
    run_word("t5", 0, 4'b0001, 1'b0, 8'b0000_1000, 1'b1);

    // 6. All-zero and all-one words, both directions
    run_word("t6 z_r", 0, 4'h0, 1'b0, 8'h00, 1'b0);
    run_word("t6 z_l", 0, 4'h0, 1'b1, 8'h00, 1'b0);
    run_word("t6 f_r", 0, 4'hF, 1'b0, 8'h0F, 1'b0);
    run_word("t6 f_l", 0, 4'hF, 1'b1, 8'h0F, 1'b0);
    run_word("t6 f_l2", 1, 4'hF, 1'b1, 8'hFF, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
